// File: rtl/spi_tx_scheduler.sv
// spi_tx_scheduler
//   Shares the SPI slave TX buffering path between NUM_REQ on-chip requesters.
//   A requester is granted round-robin for a whole packet. Its words are then
//   streamed one at a time into the buffer manager. Each word is paced on
//   i_tx_busy. The packet is aborted on a TX error, on requester withdrawal or
//   on a per-word timeout.
//
// Ports
//   i_sys_clk, i_sys_rst_n  clock, asynchronous active-low reset
//   i_req        [NUM_REQ]             per-requester packet request
//   i_req_len    [NUM_REQ*LEN_WIDTH]   packet length in words, sampled at grant
//   i_req_data   [NUM_REQ*DATA_WIDTH]  current word of each requester
//   o_req_grant  [NUM_REQ]             one-hot grant, held for the packet
//   o_req_ack    [NUM_REQ]             pulse when the current word is consumed
//   o_tx_data, o_tx_valid              word towards the buffer manager
//   i_tx_ready, i_tx_busy, i_tx_error  buffer manager status
//   o_active_id                        granted requester index, 0 when idle
//   o_pkt_done, o_pkt_abort            packet completion / abort pulses
//   o_abort_code [2]                   0 zero length, 1 tx error, 2 timeout,
//                                      3 request dropped
module spi_tx_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int ID_W          = $clog2(NUM_REQ)
) (
  input  logic                          i_sys_clk,
  input  logic                          i_sys_rst_n,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  i_req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_grant,
  output logic [NUM_REQ-1:0]            o_req_ack,
  output logic [DATA_WIDTH-1:0]         o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  input  logic                          i_tx_busy,
  input  logic                          i_tx_error,
  output logic [ID_W-1:0]               o_active_id,
  output logic                          o_pkt_done,
  output logic                          o_pkt_abort,
  output logic [1:0]                    o_abort_code
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_WACC  = 3'd2;
  localparam logic [2:0] S_WDRN  = 3'd3;
  localparam logic [2:0] S_ABORT = 3'd4;

  localparam logic [1:0] ABT_ZERO = 2'd0;
  localparam logic [1:0] ABT_ERR  = 2'd1;
  localparam logic [1:0] ABT_TMO  = 2'd2;
  localparam logic [1:0] ABT_DROP = 2'd3;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [15:0]           tmo_q, tmo_d;
  logic [1:0]            code_q, code_d;
  logic                  done_q, done_d;

  logic                  sel_found;
  logic [ID_W-1:0]       sel_id;
  logic [ID_W-1:0]       cand;
  logic [LEN_WIDTH-1:0]  sel_len;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  req_held;
  logic                  tx_valid;
  logic                  xfer;
  logic                  ack_fire;
  logic [ID_W-1:0]       ptr_next;

  // Round-robin pick: scan offsets from the highest down so the requester
  // closest at or after the pointer is the one left selected.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (i_req[cand]) begin
        sel_found = 1'b1;
        sel_id    = cand;
      end
    end
  end

  assign sel_len  = i_req_len[sel_id*LEN_WIDTH +: LEN_WIDTH];
  assign cur_data = i_req_data[id_q*DATA_WIDTH +: DATA_WIDTH];
  assign req_held = |(i_req & grant_q);
  assign tx_valid = (state_q == S_LOAD) && !i_tx_busy;
  assign xfer     = tx_valid && i_tx_ready;
  assign ptr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    code_d   = code_q;
    done_d   = 1'b0;
    ack_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          grant_d = NUM_REQ'(1) << sel_id;
          id_d    = sel_id;
          cnt_d   = sel_len;
          tmo_d   = '0;
          if (sel_len == '0) begin
            code_d  = ABT_ZERO;
            state_d = S_ABORT;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        // An error or withdrawal in the same cycle as a transfer wins, so the
        // requester is not told that the word was consumed.
        if (i_tx_error) begin
          code_d  = ABT_ERR;
          state_d = S_ABORT;
        end else if (!req_held) begin
          code_d  = ABT_DROP;
          state_d = S_ABORT;
        end else if (xfer) begin
          ack_fire = 1'b1;
          tmo_d    = '0;
          state_d  = S_WACC;
        end
      end
      S_WACC, S_WDRN: begin
        if (i_tx_error) begin
          code_d  = ABT_ERR;
          state_d = S_ABORT;
        end else if (tmo_q == TMO_LAST) begin
          code_d  = ABT_TMO;
          state_d = S_ABORT;
        end else if (!req_held) begin
          code_d  = ABT_DROP;
          state_d = S_ABORT;
        end else begin
          tmo_d = tmo_q + 16'd1;
          if (state_q == S_WACC) begin
            if (i_tx_busy) state_d = S_WDRN;
          end else if (!i_tx_busy) begin
            cnt_d = cnt_q - LEN_WIDTH'(1);
            if (cnt_q == LEN_WIDTH'(1)) begin
              done_d  = 1'b1;
              grant_d = '0;
              id_d    = '0;
              ptr_d   = ptr_next;
              state_d = S_IDLE;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      S_ABORT: begin
        grant_d = '0;
        id_d    = '0;
        ptr_d   = ptr_next;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      code_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      code_q  <= code_d;
      done_q  <= done_d;
    end
  end

  assign o_req_grant  = grant_q;
  assign o_req_ack    = grant_q & {NUM_REQ{ack_fire}};
  assign o_tx_valid   = tx_valid;
  assign o_tx_data    = (state_q == S_LOAD) ? cur_data : '0;
  assign o_active_id  = id_q;
  assign o_pkt_done   = done_q;
  assign o_pkt_abort  = (state_q == S_ABORT);
  assign o_abort_code = (state_q == S_ABORT) ? code_q : 2'b00;

endmodule
